// File: rtl/instr_issuer_if.sv
// -----------------------------------------------------------------------------
// instr_issuer_if
// Issue-side handshake bundle between the instruction issuer and the execute
// stage.
//   instr_valid   issuer -> execute  decoded instruction present
//   instr_ready   execute -> issuer  execute stage accepts
//   instr_opcode  issuer -> execute  opcode byte
//   instr_operand issuer -> execute  {byte_2, byte_1}, unused bytes zeroed
//   instr_len     issuer -> execute  instruction length 1..3
//   instr_pc      issuer -> execute  code pointer the instruction came from
//   instr_illegal issuer -> execute  opcode class 2'b11
// Modports: master (issuer side), slave (execute side).
// -----------------------------------------------------------------------------
interface instr_issuer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [1:0]  instr_len;
    logic [7:0]  instr_pc;
    logic        instr_illegal;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_operand,
        output instr_len,
        output instr_pc,
        output instr_illegal,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_operand,
        input  instr_len,
        input  instr_pc,
        input  instr_illegal,
        output instr_ready
    );
endinterface

// File: rtl/instr_issuer.sv
// -----------------------------------------------------------------------------
// instr_issuer
// Issue stage behind the fetcher. Decodes the instruction length from the
// opcode in the three-byte window at icp_value, advances icp_value by that
// length on each capture, honours the fetcher's inhibit stall and hands the
// decoded instruction to execute over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run request (low parks the block in IDLE)
//   inhibit_cpu         fetcher stall, no capture while high
//   byte_0..byte_2      cache bytes at icp_value, +1, +2
//   icp_value           registered internal code pointer to the fetcher
//   issue               master side of the issue handshake bundle
//   instr_count         accepted handshakes, saturating
//   stall_count         cycles in LOAD with inhibit_cpu high, saturating
// -----------------------------------------------------------------------------
module instr_issuer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 inhibit_cpu,
    input  logic [7:0]           byte_0,
    input  logic [7:0]           byte_1,
    input  logic [7:0]           byte_2,
    output logic [7:0]           icp_value,
    instr_issuer_if.master       issue,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t      state;
    logic        valid_r;
    logic [7:0]  opcode_r;
    logic [15:0] operand_r;
    logic [1:0]  len_r;
    logic [7:0]  pc_r;
    logic        illegal_r;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        case (op[7:6])
            2'b00:   decode_len = 2'd1;
            2'b01:   decode_len = 2'd2;
            2'b10:   decode_len = 2'd3;
            default: decode_len = 2'd1;
        endcase
    endfunction

    function automatic logic [15:0] mask_operand(input logic [1:0] len,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
        case (len)
            2'd2:    mask_operand = {8'h00, b1};
            2'd3:    mask_operand = {b2, b1};
            default: mask_operand = 16'h0000;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0] dec_len;
    logic       go;
    logic       accept;
    logic       capture;

    assign dec_len = decode_len(byte_0);
    assign go      = enable && !inhibit_cpu;
    assign accept  = (state == HOLD) && issue.instr_ready;
    // Capture either from LOAD or back-to-back right at the accepting edge.
    assign capture = go && ((state == LOAD) || accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid_r     <= 1'b0;
            icp_value   <= 8'h00;
            opcode_r    <= 8'h00;
            operand_r   <= 16'h0000;
            len_r       <= 2'd0;
            pc_r        <= 8'h00;
            illegal_r   <= 1'b0;
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (capture) begin
                opcode_r  <= byte_0;
                operand_r <= mask_operand(dec_len, byte_1, byte_2);
                len_r     <= dec_len;
                pc_r      <= icp_value;
                illegal_r <= (byte_0[7:6] == 2'b11);
                icp_value <= icp_value + {6'd0, dec_len};
            end
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (enable) state <= LOAD;
                end
                LOAD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (inhibit_cpu) begin
                        stall_count <= sat_inc(stall_count);
                    end else begin
                        valid_r <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    // Without ready everything holds; enable is looked at
                    // only once the pending instruction has been accepted.
                    if (issue.instr_ready) begin
                        instr_count <= sat_inc(instr_count);
                        if (!enable) begin
                            valid_r <= 1'b0;
                            state   <= IDLE;
                        end else if (inhibit_cpu) begin
                            valid_r <= 1'b0;
                            state   <= LOAD;
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign issue.instr_valid   = valid_r;
    assign issue.instr_opcode  = opcode_r;
    assign issue.instr_operand = operand_r;
    assign issue.instr_len     = len_r;
    assign issue.instr_pc      = pc_r;
    assign issue.instr_illegal = illegal_r;

endmodule

// File: tb/tb_instr_issuer.sv
// -----------------------------------------------------------------------------
// tb_instr_issuer
// Directed bench for instr_issuer: a 256-byte code array stands in for the
// fetcher cache and presents the window at icp_value combinationally.
// -----------------------------------------------------------------------------
module tb_instr_issuer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        inhibit_cpu = 1'b0;
    logic [7:0]  byte_0, byte_1, byte_2;
    logic [7:0]  icp_value;
    logic [15:0] instr_count, stall_count;
    logic [7:0]  mem [256];
    logic [7:0]  a1, a2;

    int n_chk = 0;
    int n_fail = 0;

    instr_issuer_if bus ();

    instr_issuer #(.CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .inhibit_cpu (inhibit_cpu),
        .byte_0      (byte_0),
        .byte_1      (byte_1),
        .byte_2      (byte_2),
        .icp_value   (icp_value),
        .issue       (bus.master),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        a1 = icp_value + 8'd1;
        a2 = icp_value + 8'd2;
        byte_0 = mem[icp_value];
        byte_1 = mem[a1];
        byte_2 = mem[a2];
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [7:0] op, input logic [15:0] opd,
                             input logic [1:0] len, input logic [7:0] pc, input logic ill);
        chk({tag, ".valid"},   {31'd0, bus.instr_valid}, 32'd1);
        chk({tag, ".opcode"},  {24'd0, bus.instr_opcode}, {24'd0, op});
        chk({tag, ".operand"}, {16'd0, bus.instr_operand}, {16'd0, opd});
        chk({tag, ".len"},     {30'd0, bus.instr_len}, {30'd0, len});
        chk({tag, ".pc"},      {24'd0, bus.instr_pc}, {24'd0, pc});
        chk({tag, ".illegal"}, {31'd0, bus.instr_illegal}, {31'd0, ill});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.instr_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        step();
        chk("rst.icp",   {24'd0, icp_value}, 32'h0);
        chk("rst.valid", {31'd0, bus.instr_valid}, 32'h0);
        chk("rst.icnt",  {16'd0, instr_count}, 32'h0);
        chk("rst.scnt",  {16'd0, stall_count}, 32'h0);
        rst_n = 1'b1;
        step();

        // Back-to-back decode
        mem[0] = 8'h05; mem[1] = 8'h41; mem[2] = 8'hAA; mem[3] = 8'h82;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'hC3;
        bus.instr_ready = 1'b1;
        enable = 1'b1;
        step();
        chk("b2b.load_valid", {31'd0, bus.instr_valid}, 32'h0);
        step();
        chk_instr("b2b.pc0", 8'h05, 16'h0000, 2'd1, 8'h00, 1'b0);
        step();
        chk_instr("b2b.pc1", 8'h41, 16'h00AA, 2'd2, 8'h01, 1'b0);
        step();
        chk_instr("b2b.pc3", 8'h82, 16'h2211, 2'd3, 8'h03, 1'b0);
        step();
        chk_instr("b2b.pc6", 8'hC3, 16'h0000, 2'd1, 8'h06, 1'b1);
        enable = 1'b0;
        step();
        chk("b2b.icp",   {24'd0, icp_value}, 32'h07);
        chk("b2b.icnt",  {16'd0, instr_count}, 32'd4);
        chk("b2b.valid", {31'd0, bus.instr_valid}, 32'h0);

        // Backpressure, with an enable drop while held
        mem[7] = 8'h4B; mem[8] = 8'h9C;
        bus.instr_ready = 1'b0;
        enable = 1'b1;
        step();
        step();
        chk_instr("bp.cap", 8'h4B, 16'h009C, 2'd2, 8'h07, 1'b0);
        chk("bp.icp0", {24'd0, icp_value}, 32'h09);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) enable = 1'b0;
            step();
            chk_instr("bp.hold", 8'h4B, 16'h009C, 2'd2, 8'h07, 1'b0);
            chk("bp.icp", {24'd0, icp_value}, 32'h09);
            chk("bp.icnt", {16'd0, instr_count}, 32'd4);
        end
        bus.instr_ready = 1'b1;
        step();
        chk("bp.acc_icnt",  {16'd0, instr_count}, 32'd5);
        chk("bp.acc_valid", {31'd0, bus.instr_valid}, 32'h0);
        step();
        chk("bp.once_icnt", {16'd0, instr_count}, 32'd5);
        chk("bp.idle_icp",  {24'd0, icp_value}, 32'h09);

        // Inhibit stall in LOAD
        mem[9] = 8'h01;
        bus.instr_ready = 1'b0;
        enable = 1'b1;
        inhibit_cpu = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("inh.valid", {31'd0, bus.instr_valid}, 32'h0);
        end
        chk("inh.scnt", {16'd0, stall_count}, 32'd5);
        inhibit_cpu = 1'b0;
        step();
        chk_instr("inh.cap", 8'h01, 16'h0000, 2'd1, 8'h09, 1'b0);
        chk("inh.icp", {24'd0, icp_value}, 32'h0A);
        chk("inh.scnt_hold", {16'd0, stall_count}, 32'd5);

        // Walk to 0xFE with len-3 opcodes, then wrap
        mem[10] = 8'h00;
        for (int i = 11; i < 256; i++) mem[i] = 8'h80;
        mem[8'hFF] = 8'h34;
        mem[0] = 8'h12;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 200 && bus.instr_pc != 8'hFE; i++) step();
        chk("wrap.reached", {24'd0, bus.instr_pc}, 32'hFE);
        chk_instr("wrap", 8'h80, 16'h1234, 2'd3, 8'hFE, 1'b0);
        chk("wrap.icp", {24'd0, icp_value}, 32'h01);
        enable = 1'b0;
        step();
        chk("wrap.icnt",  {16'd0, instr_count}, 32'd89);
        chk("wrap.valid", {31'd0, bus.instr_valid}, 32'h0);

        // Reset mid-stream
        bus.instr_ready = 1'b0;
        enable = 1'b1;
        step();
        step();
        chk_instr("mid.cap", 8'h41, 16'h00AA, 2'd2, 8'h01, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.icp",    {24'd0, icp_value}, 32'h0);
        chk("mid.valid",  {31'd0, bus.instr_valid}, 32'h0);
        chk("mid.icnt",   {16'd0, instr_count}, 32'h0);
        chk("mid.scnt",   {16'd0, stall_count}, 32'h0);
        chk("mid.opcode", {24'd0, bus.instr_opcode}, 32'h0);
        chk("mid.pc",     {24'd0, bus.instr_pc}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_issuer.md
# instr_issuer

Instruction issue stage directly downstream of the fetcher. It reads the three-byte window the fetcher presents at the internal code pointer and decodes the instruction length from the opcode. It drives the internal code pointer back to the fetcher, honours the fetcher's CPU-inhibit stall, and hands decoded instructions to the execute stage over a valid/ready handshake.

## Interface
- `CNT_WIDTH`, 16, width of the saturating `instr_count` and `stall_count` counters.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; low parks the block in IDLE.
- `inhibit_cpu`  in  1  fetcher stall: cache lead too small, no issue allowed.
- `byte_0`, `byte_1`, `byte_2`  in  8 each  cache bytes at `icp_value`, `+1`, `+2` (fetcher `data_out_0..2`).
- `icp_value`  out  8  internal code pointer to fetcher; registered.
- `instr_valid`  out  1  issued instruction present.
- `instr_ready`  in  1  execute stage accepts.
- `instr_opcode`  out  8  opcode byte.
- `instr_operand`  out  16  `{byte_2, byte_1}`; bytes beyond instruction length forced to 0.
- `instr_len`  out  2  instruction length 1..3.
- `instr_pc`  out  8  `icp_value` at which the instruction was captured.
- `instr_illegal`  out  1  opcode[7:6] == 2'b11.
- `instr_count`  out  CNT_WIDTH  accepted handshakes, saturating.
- `stall_count`  out  CNT_WIDTH  cycles spent in LOAD with `inhibit_cpu` high, saturating.

## Operation
- Length decode from opcode[7:6]: 00 → 1, 01 → 2, 10 → 3, 11 → 1 with `instr_illegal`=1.
- Operand masking:
  - len 1: operand 0x0000.
  - len 2: `{8'h00, byte_1}`.
  - len 3: `{byte_2, byte_1}`.
- Capture: register opcode, operand, len, illegal and pc from the current `icp_value`. In the same edge, `icp_value <= icp_value + len`, mod 256 (wraps 0xFF→0x00).
- FSM states: IDLE, LOAD, HOLD.
  - IDLE: `instr_valid`=0. `enable`=1 → LOAD.
  - LOAD, `enable`=0 → IDLE.
  - LOAD, `inhibit_cpu`=1 → stay in LOAD, increment `stall_count`.
  - LOAD otherwise → capture, `instr_valid`<=1, go to HOLD.
  - HOLD, `instr_ready`=0 → all `instr_*` outputs and `icp_value` frozen.
  - HOLD, `instr_ready`=1 → increment `instr_count`, then:
    - `enable`=1 and `inhibit_cpu`=0 → capture next instruction, stay in HOLD, `instr_valid` stays 1 (back-to-back).
    - `enable`=1 and `inhibit_cpu`=1 → `instr_valid`<=0, go to LOAD.
    - `enable`=0 → `instr_valid`<=0, go to IDLE.
- `instr_valid` is never withdrawn before the handshake. An `enable` drop during HOLD takes effect only after acceptance.
- Counters saturate at all-ones. No wrap.
- `inhibit_cpu` is sampled as given. The fetcher's 16-byte minimum lead covers its one-cycle staleness after `icp_value` advances by at most 3.

## Timing
- Reset (`rst_n` low, asynchronous) forces immediately:
  - `icp_value`=0, `instr_valid`=0.
  - opcode, operand, len, pc, illegal = 0.
  - both counters 0, state IDLE.
- Reset deassertion is synchronised by the integrator. Reset mid-handshake drops `instr_valid` with no completion.
- Latency: `enable` sampled high at edge E0 → LOAD; capture at E1 if not inhibited. `instr_valid` is high after E1.
- Throughput: one instruction per cycle while `instr_ready`=1 and `inhibit_cpu`=0.
- `byte_0..2` are combinational from `icp_value` in the fetcher. They are sampled at the edge that also updates `icp_value`, so the window is consistent for the next capture.
- A handshake completes at the edge where `instr_valid`=1 and `instr_ready`=1.

## Test plan
- Reset mid-stream: `rst_n` pulled low while `instr_valid`=1 → without a clock edge, `icp_value`=0, `instr_valid`=0, counters 0.
- Back-to-back decode: bench cache 0x05,0x41,0xAA,0x82,0x11,0x22,0xC3 with `instr_ready`=1. Required issue sequence:
  - pc0: op 05, len 1, operand 0000.
  - pc1: op 41, len 2, operand 00AA.
  - pc3: op 82, len 3, operand 2211.
  - pc6: op C3, len 1, illegal=1.
  - Then `icp_value`=7 and `instr_count`=4.
- Backpressure: `instr_ready` low for 3 cycles during HOLD → outputs and `icp_value` unchanged, `instr_count` unchanged. Raising `instr_ready` completes exactly one handshake.
- Inhibit stall: `inhibit_cpu` high for 5 cycles in LOAD → `instr_valid` stays 0, `stall_count`=5. First capture happens at the edge after `inhibit_cpu` falls.
- Wrap-around: `icp_value`=0xFE, cache[FE]=0x80, [FF]=0x34, [00]=0x12 → operand 0x1234, len 3, `icp_value` becomes 0x01.
- Enable drop in HOLD: `enable`=0 while `instr_ready`=0 → `instr_valid` held. Raising `instr_ready` completes the handshake, then state is IDLE with `instr_valid`=0.
